// File: rtl/id_exe_skid_stage_pkg.sv
// Shared ID->EXE pipeline definitions: bundle widths, control field layout and payload packing offsets.
// Stages that pack or unpack the payload import these offsets; the skid stage itself treats it as opaque.
package id_exe_skid_stage_pkg;

    localparam int PIPE_CTRL_W   = 10;
    localparam int PIPE_DATA_W   = 156;
    localparam int PIPE_STALL_CW = 16;

    // Control bundle bit positions
    localparam int EXE_CMD_LSB = 6;
    localparam int EXE_CMD_W   = 4;
    localparam int MEM_R_BIT   = 5;
    localparam int MEM_W_BIT   = 4;
    localparam int IMM_BIT     = 3;
    localparam int WB_BIT      = 2;
    localparam int BR_BIT      = 1;
    localparam int S_BIT       = 0;

    typedef struct packed {
        logic [EXE_CMD_W-1:0] exe_cmd;
        logic                 mem_r;
        logic                 mem_w;
        logic                 imm;
        logic                 wb;
        logic                 br;
        logic                 s;
    } ctrl_t;

    // Payload field LSBs and widths, MSB first
    localparam int PC_LSB     = 124;  localparam int PC_W     = 32;
    localparam int RN_LSB     = 92;   localparam int RN_W     = 32;
    localparam int RM_LSB     = 60;   localparam int RM_W     = 32;
    localparam int IMM24_LSB  = 36;   localparam int IMM24_W  = 24;
    localparam int SHIFT_LSB  = 24;   localparam int SHIFT_W  = 12;
    localparam int STATUS_LSB = 20;   localparam int STATUS_W = 4;
    localparam int SRC1_LSB   = 16;   localparam int SRC1_W   = 4;
    localparam int SRC2_LSB   = 12;   localparam int SRC2_W   = 4;
    localparam int DEST_LSB   = 8;    localparam int DEST_W   = 4;
    localparam int SPARE_LSB  = 0;    localparam int SPARE_W  = 8;

endpackage

// File: rtl/id_exe_skid_stage_if.sv
// Valid/ready channel carrying a control bundle plus payload; kill turns an entry into a bubble.
interface id_exe_skid_stage_if #(
    parameter int CTRL_W = id_exe_skid_stage_pkg::PIPE_CTRL_W,
    parameter int DATA_W = id_exe_skid_stage_pkg::PIPE_DATA_W
);
    logic              valid;
    logic              ready;
    logic              kill;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, kill, ctrl, data, input ready);
    modport slave  (input valid, kill, ctrl, data, output ready);
endinterface

// File: rtl/id_exe_skid_stage_slot.sv
// One pipeline holding slot: valid + ctrl + data. Clear drops valid and zeroes ctrl but keeps data.
module id_exe_skid_stage_slot #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 156
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/id_exe_skid_stage.sv
// ID->EXE boundary: main slot M drives EXE, skid slot S absorbs one entry under backpressure.
// in_ready depends only on registered state, so there is no combinational path from EXE back to ID.
module id_exe_skid_stage
    import id_exe_skid_stage_pkg::*;
#(
    parameter int CTRL_W   = PIPE_CTRL_W,
    parameter int DATA_W   = PIPE_DATA_W,
    parameter int STALL_CW = PIPE_STALL_CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                freeze_i,
    output logic [STALL_CW-1:0] stall_cnt_o,
    id_exe_skid_stage_if.slave  up_if,
    id_exe_skid_stage_if.master dn_if
);
    logic              m_valid, s_valid;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, in_ctrl;
    logic [DATA_W-1:0] m_data, s_data;
    logic              acc, deq;
    logic              m_load, m_clr, s_load, s_clr;
    logic [CTRL_W-1:0] m_ctrl_d;
    logic [DATA_W-1:0] m_data_d;
    logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;

    assign acc     = up_if.valid & ~s_valid;
    assign deq     = m_valid & dn_if.ready & ~freeze_i;
    // A killed entry still occupies a slot; only its control is squashed
    assign in_ctrl = up_if.kill ? '0 : up_if.ctrl;

    // M refills from S first so S can never overtake the entry ahead of it
    assign m_load   = ~flush_i & ((s_valid & deq) | (acc & (~m_valid | deq)));
    assign m_clr    = flush_i | (deq & ~s_valid & ~acc);
    assign m_ctrl_d = s_valid ? s_ctrl : in_ctrl;
    assign m_data_d = s_valid ? s_data : up_if.data;

    assign s_load = ~flush_i & acc & m_valid & ~deq;
    assign s_clr  = flush_i | (s_valid & deq);

    id_exe_skid_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_m_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (m_load),
        .clr_i   (m_clr),
        .ctrl_i  (m_ctrl_d),
        .data_i  (m_data_d),
        .valid_o (m_valid),
        .ctrl_o  (m_ctrl),
        .data_o  (m_data)
    );

    id_exe_skid_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_s_slot (
        .clk     (clk),
        .rst     (rst),
        .load_i  (s_load),
        .clr_i   (s_clr),
        .ctrl_i  (in_ctrl),
        .data_i  (up_if.data),
        .valid_o (s_valid),
        .ctrl_o  (s_ctrl),
        .data_o  (s_data)
    );

    // Saturating stall counter; survives flush so perf numbers span branch recovery
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid & ~deq & ~flush_i & ~(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + STALL_CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign up_if.ready = ~s_valid;
    assign dn_if.valid = m_valid;
    assign dn_if.ctrl  = m_ctrl;
    assign dn_if.data  = m_data;
    assign dn_if.kill  = 1'b0;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_id_exe_skid_stage.sv
// Directed bench for id_exe_skid_stage: the driver queues expected entries on acceptance,
// an independent monitor pops and compares on every dequeue.
module tb_id_exe_skid_stage;
    import id_exe_skid_stage_pkg::*;

    localparam int CW  = PIPE_CTRL_W;
    localparam int DW  = PIPE_DATA_W;
    localparam int SCW = 8;

    typedef logic [DW-1:0] w_t;
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           freeze;
    logic [SCW-1:0] stall_cnt;

    id_exe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) up_if ();
    id_exe_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW)) dn_if ();

    id_exe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .STALL_CW(SCW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .freeze_i    (freeze),
        .stall_cnt_o (stall_cnt),
        .up_if       (up_if),
        .dn_if       (dn_if)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    item_t exp_q[$];

    task automatic chk(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic k, input logic [CW-1:0] c, input w_t d);
        up_if.valid = v;
        up_if.kill  = k;
        up_if.ctrl  = c;
        up_if.data  = d;
    endtask

    // One clock: record acceptance before the edge, return 1 time unit after it
    task automatic tick();
        item_t it;
        @(negedge clk);
        if (up_if.valid && up_if.ready && !flush && !rst) begin
            it.c = up_if.kill ? {CW{1'b0}} : up_if.ctrl;
            it.d = up_if.data;
            exp_q.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        item_t e;
        if (!rst && dn_if.valid && dn_if.ready && !freeze && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got ctrl %0h data %0h expected no entry", dn_if.ctrl, dn_if.data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ctrl", w_t'(dn_if.ctrl), w_t'(e.c));
                chk("sb_data", dn_if.data, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] c;
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        dn_if.ready = 1'b0;
        set_in(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", w_t'(dn_if.valid), w_t'(0));
        chk("rst_out_ctrl",  w_t'(dn_if.ctrl),  w_t'(0));
        chk("rst_out_data",  dn_if.data,        w_t'(0));
        chk("rst_in_ready",  w_t'(up_if.ready), w_t'(1));
        chk("rst_stall",     w_t'(stall_cnt),   w_t'(0));

        // Streaming: each entry visible one cycle after acceptance, no gaps
        dn_if.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c = 10'h2A5 + CW'(i);
            set_in(1'b1, 1'b0, c, {w_t'(i), 32'hA000_0000} + w_t'(i));
            tick();
            chk("stream_valid", w_t'(dn_if.valid), w_t'(1));
            chk("stream_ctrl",  w_t'(dn_if.ctrl),  w_t'(c));
            chk("stream_ready", w_t'(up_if.ready), w_t'(1));
        end
        set_in(1'b0, 1'b0, '0, '0);
        tick();
        chk("stream_drain", w_t'(dn_if.valid), w_t'(0));
        chk("stream_stall", w_t'(stall_cnt),   w_t'(0));

        // Backpressure: A held, B in skid, C waits upstream
        dn_if.ready = 1'b0;
        set_in(1'b1, 1'b0, 10'h101, w_t'('hA));
        tick();
        chk("bp_a_out",   dn_if.data,        w_t'('hA));
        chk("bp_a_ready", w_t'(up_if.ready), w_t'(1));
        set_in(1'b1, 1'b0, 10'h102, w_t'('hB));
        tick();
        chk("bp_b_ready", w_t'(up_if.ready), w_t'(0));
        chk("bp_b_hold",  dn_if.data,        w_t'('hA));
        set_in(1'b1, 1'b0, 10'h103, w_t'('hC));
        tick();
        chk("bp_c_hold",  dn_if.data,        w_t'('hA));
        chk("bp_c_ctrl",  w_t'(dn_if.ctrl),  w_t'(10'h101));
        chk("bp_c_ready", w_t'(up_if.ready), w_t'(0));
        tick();
        chk("bp_stall3", w_t'(stall_cnt), w_t'(3));
        dn_if.ready = 1'b1;
        tick();
        chk("bp_rel_b",  dn_if.data,        w_t'('hB));
        chk("bp_rel_rd", w_t'(up_if.ready), w_t'(1));
        tick();
        chk("bp_rel_c", dn_if.data, w_t'('hC));
        set_in(1'b0, 1'b0, '0, '0);
        tick();
        chk("bp_empty",     w_t'(dn_if.valid), w_t'(0));
        chk("bp_stall_end", w_t'(stall_cnt),   w_t'(3));

        // Kill: bubble keeps data and valid, ctrl squashed
        set_in(1'b1, 1'b1, 10'h3FF, w_t'('h123));
        tick();
        chk("kill_valid", w_t'(dn_if.valid), w_t'(1));
        chk("kill_ctrl",  w_t'(dn_if.ctrl),  w_t'(0));
        chk("kill_data",  dn_if.data,        w_t'('h123));
        set_in(1'b0, 1'b0, '0, '0);
        tick();

        // Flush with both slots full and a new entry offered
        dn_if.ready = 1'b0;
        set_in(1'b1, 1'b0, 10'h111, w_t'('hD));
        tick();
        set_in(1'b1, 1'b0, 10'h112, w_t'('hE));
        tick();
        set_in(1'b1, 1'b0, 10'h113, w_t'('hF));
        flush = 1'b1;
        tick();
        exp_q.delete();
        chk("flush_valid", w_t'(dn_if.valid), w_t'(0));
        chk("flush_ctrl",  w_t'(dn_if.ctrl),  w_t'(0));
        chk("flush_ready", w_t'(up_if.ready), w_t'(1));
        flush = 1'b0;
        set_in(1'b0, 1'b0, '0, '0);
        dn_if.ready = 1'b1;
        tick();
        chk("flush_drop",  w_t'(dn_if.valid), w_t'(0));
        chk("flush_stall", w_t'(stall_cnt),   w_t'(4));

        // Freeze behaves as out_ready low
        freeze = 1'b1;
        set_in(1'b1, 1'b0, 10'h121, w_t'('h77));
        tick();
        set_in(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        chk("frz_hold",  dn_if.data,        w_t'('h77));
        chk("frz_valid", w_t'(dn_if.valid), w_t'(1));
        chk("frz_stall", w_t'(stall_cnt),   w_t'(6));
        freeze = 1'b0;
        tick();
        chk("frz_release", w_t'(dn_if.valid), w_t'(0));

        // Stall counter saturation, and flush leaves it alone
        freeze = 1'b1;
        set_in(1'b1, 1'b0, 10'h131, w_t'('h88));
        tick();
        set_in(1'b0, 1'b0, '0, '0);
        repeat (300) tick();
        chk("sat_max", w_t'(stall_cnt), w_t'({SCW{1'b1}}));
        tick();
        chk("sat_hold", w_t'(stall_cnt), w_t'({SCW{1'b1}}));
        flush = 1'b1;
        tick();
        exp_q.delete();
        flush = 1'b0;
        freeze = 1'b0;
        chk("sat_flush_keep",  w_t'(stall_cnt),   w_t'({SCW{1'b1}}));
        chk("sat_flush_valid", w_t'(dn_if.valid), w_t'(0));

        // Asynchronous reset with both slots occupied
        dn_if.ready = 1'b0;
        set_in(1'b1, 1'b0, 10'h141, w_t'('h91));
        tick();
        set_in(1'b1, 1'b0, 10'h142, w_t'('h92));
        tick();
        chk("mid_full", w_t'(up_if.ready), w_t'(0));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", w_t'(dn_if.valid), w_t'(0));
        chk("mid_rst_ctrl",  w_t'(dn_if.ctrl),  w_t'(0));
        chk("mid_rst_data",  dn_if.data,        w_t'(0));
        chk("mid_rst_ready", w_t'(up_if.ready), w_t'(1));
        chk("mid_rst_stall", w_t'(stall_cnt),   w_t'(0));
        exp_q.delete();
        set_in(1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        chk("sb_empty", w_t'(exp_q.size()), w_t'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
